bin_to_bcd_blanker: RTL and testbench
=====================================

BIN_TO_BCD_BLANKER -- requirements
Module: bin_to_bcd_blanker

Interface
REQ-001 SHALL have parameter LEAD_BLANK, default 1: 1 = blank leading zero digits; 0 = show all eight digits.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: ports clock and reset_L.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset_L  input  1  async active-low reset.
REQ-005 start  input  1  request a conversion of bin; sampled on clock edges only in IDLE.
REQ-006 bin  input  27  unsigned binary value, sampled on the accepting edge.
REQ-007 BCD7..BCD0  output  4 each  registered decimal digits, BCD7 = most significant.
REQ-008 blank  output  8  registered per-digit blank mask, bit i for BCDi, 1 = blank.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when new outputs become valid.
REQ-011 overflow  output  1  registered; 1 = last accepted bin exceeded 99,999,999.

Function
REQ-012 SHALL implement states IDLE, CONV and DONE.
REQ-013 Transition IDLE->CONV on an edge with start=1; that edge loads bin into a 27-bit shift field, clears a 32-bit BCD field, clears the shift counter, and latches ovf = (bin > 99,999,999).
REQ-014 In CONV, each edge SHALL double-dabble: add 3 to every BCD nibble >= 5, then shift {BCD, bin} left by one bit.
REQ-015 CONV->DONE SHALL occur on the 27th shift edge; the counter is 5 bits, range 0..26.
REQ-016 DONE->IDLE SHALL occur after one cycle; that edge loads BCD7..BCD0, blank and overflow, and sets done=1 for exactly the following cycle.
REQ-017 Latency SHALL be exactly 28 edges from the start-accepting edge k to outputs valid: shifts on k+1..k+27, load on k+28, done high between k+28 and k+29.
REQ-018 start while busy=1 SHALL be ignored, with no queueing and no effect on the result in progress.
REQ-019 start=1 in IDLE during the done pulse SHALL be accepted; done still falls after one cycle.
REQ-020 BCD, blank and overflow SHALL hold their values between completions and change only on the DONE->IDLE edge.
REQ-021 With LEAD_BLANK=1 and ovf=0: blank[i]=1 iff i>0 and BCD7..BCDi are all zero; blank[0] is always 0.
REQ-022 With LEAD_BLANK=0 and ovf=0, blank SHALL be 8'h00.
REQ-023 With ovf=1: overflow=1, all BCD digits=0, blank=8'hFF, regardless of LEAD_BLANK.
REQ-024 With ovf=0, overflow SHALL be 0 on load.
REQ-025 Every BCD output digit SHALL be in the range 0..9.

Reset
REQ-026 reset_L=0 SHALL act immediately, independent of clock: state=IDLE, BCD7..BCD0=0, blank=8'hFE (LEAD_BLANK=1) or 8'h00 (LEAD_BLANK=0), busy=0, done=0, overflow=0, counter and shift fields cleared.
REQ-027 Reset during CONV or DONE SHALL abort the conversion with no done pulse; the first start after reset_L rises SHALL convert normally.

Verification
REQ-028 Reset then idle 5 cycles -> all BCD=0, blank=8'hFE, busy=0, done=0, overflow=0.
REQ-029 bin=12345, start at edge k -> busy for 28 cycles; at k+28: BCD4..BCD0=1,2,3,4,5, BCD7..BCD5=0, blank=8'hE0, done high one cycle.
REQ-030 Back-to-back: bin=99,999,999 -> all digits 9, blank=8'h00, overflow=0; start on the done cycle with bin=100,000,000 -> overflow=1, blank=8'hFF, digits 0.
REQ-031 bin=0 -> BCD all 0, blank=8'hFE; bin=10 -> blank=8'hFC; bin=1000 -> blank=8'hF0; with LEAD_BLANK=0, bin=10 -> blank=8'h00.
REQ-032 Start at edge k with bin=42, then start at k+10 with bin=7 -> second start ignored; result 42, exactly one done at k+28.
REQ-033 reset_L low for 2 cycles after the 13th shift -> outputs return to reset values with no done; a new start with bin=5 then gives BCD0=5, blank=8'hFE, 28 edges later.

Source files
------------

// File: rtl/bin_to_bcd_blanker.sv
// Sequential 27-bit binary to 8-digit BCD converter (double dabble, one bit per
// cycle) with registered outputs, optional leading-zero blanking and overflow
// indication for values above 99,999,999.
module bin_to_bcd_blanker #(
  parameter int unsigned LEAD_BLANK = 1
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic        start,
  input  logic [26:0] bin,
  output logic [3:0]  BCD7,
  output logic [3:0]  BCD6,
  output logic [3:0]  BCD5,
  output logic [3:0]  BCD4,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic [7:0]  blank,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [26:0] MaxVal   = 27'd99_999_999;
  localparam logic [4:0]  LastCnt  = 5'd26;
  localparam logic [7:0]  BlankRst = (LEAD_BLANK != 0) ? 8'hFE : 8'h00;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [26:0] r_shift;
  logic [31:0] r_bcd;
  logic [4:0]  r_cnt;
  logic        r_ovf;
  logic [31:0] r_bcd_out;
  logic [7:0]  r_blank;
  logic        r_overflow;
  logic        r_done;
  logic [31:0] w_bcd_adj;
  logic [7:0]  w_blank_lz;

  // State register.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: 27 shifts in CONV, then a single load cycle in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (start) w_state_nxt = StConv;
      StConv:  if (r_cnt == LastCnt) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (r_state != StIdle);
  end

  // Add-3 correction of every BCD nibble that would overflow on doubling.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 8; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: digit i is blanked when it and every digit above it are zero.
  always_comb begin
    logic v_zero;
    v_zero     = 1'b1;
    w_blank_lz = 8'h00;
    for (int i = 7; i >= 1; i--) begin
      v_zero        = v_zero & (r_bcd[4*i +: 4] == 4'd0);
      w_blank_lz[i] = v_zero;
    end
  end

  // Conversion datapath: capture on accept, shift {BCD, bin} left in CONV.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_shift <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= (bin > MaxVal);
          end
        end
        StConv: begin
          r_bcd   <= (w_bcd_adj << 1) | {31'd0, r_shift[26]};
          r_shift <= r_shift << 1;
          r_cnt   <= (r_cnt == LastCnt) ? 5'd0 : r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Output registers: updated only on the DONE->IDLE edge; done pulses one cycle.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_bcd_out  <= '0;
      r_blank    <= BlankRst;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == StDone);
      if (r_state == StDone) begin
        if (r_ovf) begin
          r_bcd_out  <= '0;
          r_blank    <= 8'hFF;
          r_overflow <= 1'b1;
        end else begin
          r_bcd_out  <= r_bcd;
          r_blank    <= (LEAD_BLANK != 0) ? w_blank_lz : 8'h00;
          r_overflow <= 1'b0;
        end
      end
    end
  end

  assign BCD7     = r_bcd_out[31:28];
  assign BCD6     = r_bcd_out[27:24];
  assign BCD5     = r_bcd_out[23:20];
  assign BCD4     = r_bcd_out[19:16];
  assign BCD3     = r_bcd_out[15:12];
  assign BCD2     = r_bcd_out[11:8];
  assign BCD1     = r_bcd_out[7:4];
  assign BCD0     = r_bcd_out[3:0];
  assign blank    = r_blank;
  assign overflow = r_overflow;
  assign done     = r_done;

endmodule

// File: tb/tb_bin_to_bcd_blanker.sv
// Directed bench for bin_to_bcd_blanker: two instances (blanking on / off) share
// stimulus; expected results are queued at start and checked when done pulses.
module tb_bin_to_bcd_blanker;

  logic        clock   = 1'b0;
  logic        reset_L = 1'b0;
  logic        start   = 1'b0;
  logic [26:0] bin     = '0;

  logic [3:0] a7, a6, a5, a4, a3, a2, a1, a0;
  logic [3:0] b7, b6, b5, b4, b3, b2, b1, b0;
  logic [7:0] a_blank, b_blank;
  logic       a_busy, a_done, a_ovf;
  logic       b_busy, b_done, b_ovf;
  logic [31:0] a_bcd, b_bcd;

  always #5 clock = ~clock;

  bin_to_bcd_blanker #(.LEAD_BLANK(1)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .bin(bin),
    .BCD7(a7), .BCD6(a6), .BCD5(a5), .BCD4(a4),
    .BCD3(a3), .BCD2(a2), .BCD1(a1), .BCD0(a0),
    .blank(a_blank), .busy(a_busy), .done(a_done), .overflow(a_ovf)
  );

  bin_to_bcd_blanker #(.LEAD_BLANK(0)) dut_nb (
    .clock(clock), .reset_L(reset_L), .start(start), .bin(bin),
    .BCD7(b7), .BCD6(b6), .BCD5(b5), .BCD4(b4),
    .BCD3(b3), .BCD2(b2), .BCD1(b1), .BCD0(b0),
    .blank(b_blank), .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  assign a_bcd = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign b_bcd = {b7, b6, b5, b4, b3, b2, b1, b0};

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  blank1;
    logic [7:0]  blank0;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  exp_t        rst_exp;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: digits by repeated division, blank mask from the decimal digit count.
  function automatic exp_t model(input logic [26:0] v);
    exp_t        m;
    int unsigned x;
    int          nd;
    x = 32'(v);
    if (x > 99_999_999) begin
      m.bcd = '0; m.blank1 = 8'hFF; m.blank0 = 8'hFF; m.ovf = 1'b1;
    end else begin
      m.bcd = '0; m.ovf = 1'b0; m.blank0 = 8'h00;
      for (int i = 0; i < 8; i++) begin
        m.bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
      x  = 32'(v);
      nd = 1;
      while (x >= 10) begin
        x = x / 10;
        nd++;
      end
      m.blank1 = 8'hFF << nd;
    end
    return m;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, "_bcd"},      a_bcd,   e.bcd);
    chk({tag, "_blank"},    a_blank, {24'd0, e.blank1});
    chk({tag, "_ovf"},      a_ovf,   {31'd0, e.ovf});
    chk({tag, "_bcd_nb"},   b_bcd,   e.bcd);
    chk({tag, "_blank_nb"}, b_blank, {24'd0, e.blank0});
    chk({tag, "_ovf_nb"},   b_ovf,   {31'd0, e.ovf});
  endtask

  // Drive start at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [26:0] v);
    bin   = v;
    start = 1'b1;
    sb.push_back(model(v));
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    bin   = 27'($urandom);
    chk("busy_after_accept", a_busy, 1);
  endtask

  // Count edges after the accepting edge until done is seen; check latency and result.
  task automatic wait_done(input string tag, input int start_n);
    int   n;
    exp_t e;
    n = start_n;
    while (a_done !== 1'b1 && n < 60) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 27) chk({tag, "_hold"}, a_bcd, last.bcd);
    end
    chk({tag, "_latency"}, 32'(n), 32'd28);
    chk({tag, "_done_nb"}, b_done, 1);
    chk({tag, "_idle"}, a_busy, 0);
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_outputs(tag, e);
      last = e;
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (a_done !== 1'b0 || b_done !== 1'b0) hits++;
    end
    chk(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    logic [26:0] v;
    rst_exp = '{bcd: 32'h0, blank1: 8'hFE, blank0: 8'h00, ovf: 1'b0};
    last    = rst_exp;

    // Reset then idle
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    repeat (5) @(negedge clock);
    check_outputs("reset", rst_exp);
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);

    // Basic conversion
    launch(27'd12345);
    wait_done("d12345", 0);
    chk("d12345_literal_blank", a_blank, 32'hE0);
    @(negedge clock);
    chk("d12345_done_width", a_done, 0);

    // Back-to-back: second start issued during the done cycle
    launch(27'd99_999_999);
    wait_done("d99999999", 0);
    launch(27'd100_000_000);
    chk("chain_done_falls", a_done, 0);
    wait_done("d100000000", 0);
    @(negedge clock);

    // Blanking boundaries
    launch(27'd0);    wait_done("d0", 0);    @(negedge clock);
    launch(27'd10);   wait_done("d10", 0);   @(negedge clock);
    launch(27'd1000); wait_done("d1000", 0); @(negedge clock);

    // A few random in-range values and one overflow
    repeat (4) begin
      v = 27'($urandom_range(0, 99_999_999));
      launch(v);
      wait_done("rand", 0);
      @(negedge clock);
    end
    v = 27'($urandom_range(100_000_000, 134_217_727));
    launch(v);
    wait_done("rand_ovf", 0);
    @(negedge clock);

    // Start while busy is ignored
    launch(27'd42);
    repeat (9) @(negedge clock);
    bin   = 27'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("d42_ignore", 10);
    expect_no_done("no_second_done", 35);

    // Reset after the 13th shift aborts the conversion
    launch(27'd123);
    repeat (13) @(negedge clock);
    reset_L = 1'b0;
    #1;
    check_outputs("reset_async", rst_exp);
    chk("reset_async_busy", a_busy, 0);
    chk("reset_async_done", a_done, 0);
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    sb.delete();
    last = rst_exp;
    expect_no_done("no_done_after_abort", 35);
    launch(27'd5);
    wait_done("d5_after_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
